// File: rtl/fp_addsub_seq.sv
// Sequencer for IEEE-754 single-precision add/subtract around an external
// combinational sign-magnitude BigAlu: unpack, serial align, add, serial normalise, pack.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic                   ready,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [MAN_W:0]         alu_a,
  output logic [MAN_W:0]         alu_b,
  output logic                   alu_sign_a,
  output logic                   alu_sign_b,
  output logic                   alu_symbol,
  input  logic [MAN_W+1:0]       alu_out,
  input  logic                   alu_sign_out
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX  = EXP_W'(2 * BIAS + 1);
  localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(2 * BIAS);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W + 1);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  state_t state;

  logic [MAN_W:0]   man_a, man_b;
  logic             sign_a, sign_b, symbol;
  logic [EXP_W-1:0] exp_a, diff, exp_r;
  logic [MAN_W+1:0] sum;
  logic             sum_sign;
  logic             special;
  logic [W-1:0]     spec_res;

  function automatic logic [W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                        input logic [MAN_W-1:0] f);
    return {s, e, f};
  endfunction

  function automatic logic [W-1:0] infinity(input logic s);
    return pack(s, EXP_MAX, '0);
  endfunction

  // Request unpack; exponent 0 flushes the operand to zero.
  logic             sa, sb, sb_eff;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, spec_hit;
  logic [W-1:0]     spec_val;

  assign {sa, ea, fa} = op_a;
  assign {sb, eb, fb} = op_b;
  assign sb_eff = sb ^ op;
  assign ma     = (ea != '0) ? {1'b1, fa} : '0;
  assign mb     = (eb != '0) ? {1'b1, fb} : '0;
  assign a_nan  = (ea == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == EXP_MAX) && (fb != '0);
  assign a_inf  = (ea == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == EXP_MAX) && (fb == '0);
  assign spec_hit = a_nan | b_nan | a_inf | b_inf;

  always_comb begin
    spec_val = infinity(sb_eff);
    if (a_nan || b_nan)      spec_val = QNAN;
    else if (a_inf && b_inf) spec_val = (sa != sb_eff) ? QNAN : infinity(sa);
    else if (a_inf)          spec_val = infinity(sa);
  end

  assign alu_a      = man_a;
  assign alu_b      = man_b;
  assign alu_sign_a = sign_a;
  assign alu_sign_b = sign_b;
  assign alu_symbol = symbol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      man_a    <= '0;
      man_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      symbol   <= 1'b0;
      exp_a    <= '0;
      diff     <= '0;
      exp_r    <= '0;
      sum      <= '0;
      sum_sign <= 1'b0;
      special  <= 1'b0;
      spec_res <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ready    <= 1'b0;
          special  <= spec_hit;
          spec_res <= spec_val;
          // Swapping turns A-B into (-B)+A so the larger exponent always sits on port a.
          if (eb > ea) begin
            man_a  <= mb;
            man_b  <= ma;
            exp_a  <= eb;
            diff   <= eb - ea;
            sign_a <= sb_eff;
            sign_b <= sa;
            symbol <= 1'b0;
          end else begin
            man_a  <= ma;
            man_b  <= mb;
            exp_a  <= ea;
            diff   <= ea - eb;
            sign_a <= sa;
            sign_b <= sb;
            symbol <= op;
          end
          // Specials pass through NORM so their done lands one cycle after accept.
          state <= spec_hit ? S_NORM : S_ALIGN;
        end
        S_ALIGN: begin
          if (diff == '0) begin
            state <= S_ADD;
          end else if (diff > SHIFT_LIM) begin
            man_b <= '0;
            diff  <= '0;
          end else begin
            man_b <= man_b >> 1;
            diff  <= diff - EXP_ONE;
          end
        end
        S_ADD: begin
          sum      <= alu_out;
          sum_sign <= alu_sign_out;
          exp_r    <= exp_a;
          state    <= S_NORM;
        end
        S_NORM: begin
          if (special) begin
            result <= spec_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (sum == '0) begin
            result <= '0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (sum[MAN_W+1]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + EXP_ONE;
            if (exp_r == EXP_TOP) begin
              result <= infinity(sum_sign);
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end else if (!sum[MAN_W]) begin
            if (exp_r == EXP_ONE) begin
              result <= pack(sum_sign, '0, '0);
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              sum   <= sum << 1;
              exp_r <= exp_r - EXP_ONE;
            end
          end else begin
            result <= pack(sum_sign, exp_r, sum[MAN_W-1:0]);
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq with a behavioural BigAlu on the alu_* ports.
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ready, done;
  logic [31:0] result;
  logic [23:0] alu_a, alu_b;
  logic        alu_sign_a, alu_sign_b, alu_symbol;
  logic [24:0] alu_out;
  logic        alu_sign_out;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .ready(ready), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sign_a(alu_sign_a), .alu_sign_b(alu_sign_b),
    .alu_symbol(alu_symbol), .alu_out(alu_out), .alu_sign_out(alu_sign_out)
  );

  always #5 clk = ~clk;

  // Sign-magnitude adder: symbol=1 negates b.
  logic alu_eff_b;
  always_comb begin
    alu_eff_b    = alu_sign_b ^ alu_symbol;
    alu_out      = '0;
    alu_sign_out = alu_sign_a;
    if (alu_sign_a == alu_eff_b) begin
      alu_out = {1'b0, alu_a} + {1'b0, alu_b};
    end else if (alu_a >= alu_b) begin
      alu_out = {1'b0, alu_a} - {1'b0, alu_b};
    end else begin
      alu_out      = {1'b0, alu_b} - {1'b0, alu_a};
      alu_sign_out = alu_eff_b;
    end
  end

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;
  int   cyc = 0, done_cnt = 0, push_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h, expected no done", result);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        if (mon_e.lat > 0) check({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] r, input int lat, input string nm);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got ready=0, expected ready=1 within 300 cycles", nm);
      return;
    end
    op_a = a; op_b = b; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.res = r; e.acc = cyc; e.lat = lat; e.name = nm;
    q.push_back(e);
    push_cnt++;
    check({nm, "_ready_low"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, expected done within 300 cycles", nm);
      q.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic o,
                     input logic [31:0] r, input int lat, input string nm);
    launch(a, b, o, r, lat, nm);
    drain(nm);
  endtask

  initial begin
    int t;
    #12;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_alu_a", {8'b0, alu_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4,  "one_plus_two");
    run(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4,  "sub_lshift");
    run(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4,  "sub_swapped");
    run(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3,  "sub_zero");
    run(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4,  "far_shortcut");
    run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 27, "diff24_trunc");
    run(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 26, "diff23_lsb");
    run(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 3,  "neg_zeros");
    run(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3,  "underflow_flush");
    run(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4,  "denorm_flush");
    run(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1,  "nan_in");
    run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1,  "inf_minus_inf");
    run(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1,  "neg_inf_a");
    run(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1,  "minus_inf_b");
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 0,  "overflow_inf");
    run(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 5,  "carry_norm");

    // Abandon a diff=20 operation with an asynchronous reset mid-ALIGN.
    launch(32'h49800000, 32'h3F800000, 1'b0, 32'h49800008, 24, "reset_victim");
    repeat (5) @(negedge clk);
    q.delete();
    push_cnt--;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, ready}, 32'd1);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, "after_reset");

    // Starts while busy and in the DONE cycle must be ignored.
    launch(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4, "busy_first");
    op_a = 32'h7FC00001; op_b = 32'h40400000; op = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("done_count", done_cnt, push_cnt);
    check("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end
endmodule
